// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch stage with the IF/ID pipeline register.
//   Holds the PC, issues instruction-memory requests, captures the returned
//   instruction into IF/ID and decodes rs1/rs2 for the downstream hazard unit.
//   Honours stall (hold everything) and flush (squash IF/ID, redirect PC).
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   stall, flush         hazard-unit controls (flush has priority)
//   branch_target        redirect address, used when flush=1
//   imem_req/imem_addr   fetch request and address (address = PC register)
//   imem_rdata/ready     fetched instruction and its valid strobe
//   IF_ID_*              IF/ID register contents and rs1/rs2 slices
//   bubble_cnt           saturating count of bubbles inserted in RUN
module if_id_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_instr,
  output logic            IF_ID_valid,
  output logic [4:0]      IF_ID_rs1,
  output logic [4:0]      IF_ID_rs2,
  output logic [15:0]     bubble_cnt
);

  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [CNTW-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic              load_bubble;
  logic              count_bubble;

  // Next-state: BOOT idles one cycle, RUN applies flush > stall > !ready > load
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    bubble_cnt_d = bubble_cnt_q;
    load_bubble  = 1'b0;
    count_bubble = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d     = RUN;
        load_bubble = 1'b1;
      end
      RUN: begin
        if (flush) begin
          // Redirect to a word-aligned target; this cycle's response is dropped
          pc_d         = {branch_target[XLEN-1:2], 2'b00};
          load_bubble  = 1'b1;
          count_bubble = 1'b1;
        end else if (stall) begin
          // Hold everything; the same address is re-fetched next cycle
        end else if (!imem_ready) begin
          load_bubble  = 1'b1;
          count_bubble = 1'b1;
        end else begin
          ifid_instr_d = imem_rdata;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + XLEN'(4);
        end
      end
      default: state_d = BOOT;
    endcase

    if (load_bubble) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end

    if (count_bubble && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNTW'(1);
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Request is a pure decode of the state register, so no input reaches it
  assign imem_req    = (state_q == RUN);
  assign imem_addr   = pc_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;
  assign IF_ID_rs1   = ifid_instr_q[19:15];
  assign IF_ID_rs2   = ifid_instr_q[24:20];
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, random run against a
// reference model, async reset mid-cycle and bubble counter saturation.
module tb_if_id_stage;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic            clk;
  logic            rstn;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] branch_target;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;
  logic [XLEN-1:0] IF_ID_pc;
  logic [31:0]     IF_ID_instr;
  logic            IF_ID_valid;
  logic [4:0]      IF_ID_rs1;
  logic [4:0]      IF_ID_rs2;
  logic [15:0]     bubble_cnt;

  int checks;
  int failures;

  if_id_stage #(
    .XLEN      (XLEN),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_valid   (IF_ID_valid),
    .IF_ID_rs1     (IF_ID_rs1),
    .IF_ID_rs2     (IF_ID_rs2),
    .bubble_cnt    (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] bt;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_ifpc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[14];

  // Reference model state, advanced once per clock edge from the rules
  bit          m_running;
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid;
  int          m_bubbles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_ifpc, input logic e_valid,
                           input logic [31:0] e_instr, input logic [15:0] e_cnt);
    check({tag, ".req"},   32'(imem_req),    32'(e_req));
    check({tag, ".addr"},  imem_addr,        e_addr);
    check({tag, ".ifpc"},  IF_ID_pc,         e_ifpc);
    check({tag, ".valid"}, 32'(IF_ID_valid), 32'(e_valid));
    check({tag, ".instr"}, IF_ID_instr,      e_instr);
    check({tag, ".rs1"},   32'(IF_ID_rs1),   32'(e_instr[19:15]));
    check({tag, ".rs2"},   32'(IF_ID_rs2),   32'(e_instr[24:20]));
    check({tag, ".cnt"},   32'(bubble_cnt),  32'(e_cnt));
  endtask

  function automatic void model_reset();
    m_running = 1'b0;
    m_pc      = 32'h0;
    m_ifpc    = 32'h0;
    m_instr   = NOP;
    m_valid   = 1'b0;
    m_bubbles = 0;
  endfunction

  function automatic void model_bubble(input bit counted);
    m_instr = NOP;
    m_valid = 1'b0;
    m_ifpc  = 32'h0;
    if (counted) m_bubbles++;
  endfunction

  function automatic void model_edge(input logic s, input logic f, input logic [31:0] bt,
                                     input logic rdy, input logic [31:0] rd);
    if (!m_running) begin
      m_running = 1'b1;
      model_bubble(1'b0);
    end else if (f) begin
      m_pc = bt & ~32'd3;
      model_bubble(1'b1);
    end else if (s) begin
      // nothing changes
    end else if (!rdy) begin
      model_bubble(1'b1);
    end else begin
      m_instr = rd;
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endfunction

  function automatic logic [15:0] model_cnt();
    return (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
  endfunction

  // Apply one cycle of inputs, advance the model on the edge, sample after it
  task automatic step(input logic s, input logic f, input logic [31:0] bt,
                      input logic rdy, input logic [31:0] rd);
    stall = s; flush = f; branch_target = bt; imem_ready = rdy; imem_rdata = rd;
    @(posedge clk);
    model_edge(s, f, bt, rdy, rd);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    stall = 1'b0; flush = 1'b0; branch_target = '0; imem_ready = 1'b0; imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn = 1'b0;

    // Directed sequence from reset: {stall, flush, bt, ready, rdata, addr, ifpc, valid, instr, cnt}
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, JUNK,         32'h0,   32'h0,   1'b0, NOP,          16'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0020_8033, 32'h4,   32'h0,   1'b1, 32'h0020_8033, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h01F5_0A63, 32'h8,   32'h4,   1'b1, 32'h01F5_0A63, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, JUNK,         32'h8,   32'h4,   1'b1, 32'h01F5_0A63, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, JUNK,         32'h8,   32'h4,   1'b1, 32'h01F5_0A63, 16'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00C6_8733, 32'hC,   32'h8,   1'b1, 32'h00C6_8733, 16'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0157_0833, 32'h10,  32'hC,   1'b1, 32'h0157_0833, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'h103, 1'b1, JUNK,         32'h100, 32'h0,   1'b0, NOP,          16'd1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0098_8933, 32'h104, 32'h100, 1'b1, 32'h0098_8933, 16'd1};
    vecs[9]  = '{1'b1, 1'b1, 32'h203, 1'b1, JUNK,         32'h200, 32'h0,   1'b0, NOP,          16'd2};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, JUNK,         32'h200, 32'h0,   1'b0, NOP,          16'd3};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, JUNK,         32'h200, 32'h0,   1'b0, NOP,          16'd4};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, JUNK,         32'h200, 32'h0,   1'b0, NOP,          16'd5};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h01AC_8B33, 32'h204, 32'h200, 1'b1, 32'h01AC_8B33, 16'd5};

    do_reset();
    check_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, NOP, 16'd0);
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].stall, vecs[i].flush, vecs[i].bt, vecs[i].ready, vecs[i].rdata);
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].e_addr, vecs[i].e_ifpc,
                vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_cnt);
    end

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 3) != 0), $urandom);
      check_all($sformatf("rnd%0d", i), m_running, m_pc, m_ifpc, m_valid, m_instr, model_cnt());
    end

    // Asynchronous reset between edges, then restart from RESET_PC
    @(posedge clk);
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, NOP, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1, JUNK);
    check_all("post_rst_boot", 1'b1, 32'h0, 32'h0, 1'b0, NOP, 16'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0031_0133);
    check_all("post_rst_fetch", 1'b1, 32'h4, 32'h0, 1'b1, 32'h0031_0133, 16'd0);

    // Saturation: 65535 bubbles reach the ceiling, 5 more must not wrap
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, JUNK);
    imem_ready = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_before", 32'(bubble_cnt), 32'h0000_FFFE);
    @(posedge clk);
    #1;
    check("sat_reach", 32'(bubble_cnt), 32'h0000_FFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", 32'(bubble_cnt), 32'h0000_FFFF);
    check("sat_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
